// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath blocks.
package accel_pkg;

    // Default datapath word width.
    localparam int unsigned ACC_DATA_W = 32;

    // Level of rst that means "in reset".
    localparam logic RST_ACTIVE = 1'b1;

    // Width needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word. The stage advances when it is
// empty or when the stage downstream of it advances.
module reg_pipe_stage
    import accel_pkg::*;
#(
    parameter int unsigned      WIDTH      = ACC_DATA_W,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             down_adv_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             adv_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign adv_o   = ~valid_q | down_adv_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next state: flush clears valid only; data loads solely on a real upstream word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (adv_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            valid_q <= 1'b0;
            data_q  <= RESET_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, synchronous
// flush and an occupancy count.
module reg_pipe
    import accel_pkg::*;
#(
    parameter int unsigned      WIDTH      = ACC_DATA_W,
    parameter int unsigned      DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int unsigned OccW = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // Advance signals live per generate block so the ready chain is a set of
    // distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             adv_s;
        logic             down_adv_s;
        logic             up_valid_s;
        logic [WIDTH-1:0] up_data_s;

        if (i == 0) begin : g_first
            assign up_valid_s = in_valid & in_ready;
            assign up_data_s  = in_data;
        end else begin : g_rest
            assign up_valid_s = v[i-1];
            assign up_data_s  = d[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign down_adv_s = out_ready;
        end else begin : g_mid
            assign down_adv_s = g_stage[i+1].adv_s;
        end

        reg_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush),
            .up_valid_i (up_valid_s),
            .up_data_i  (up_data_s),
            .down_adv_i (down_adv_s),
            .valid_o    (v[i]),
            .data_o     (d[i]),
            .adv_o      (adv_s)
        );
    end

    assign in_ready  = g_stage[0].adv_s & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Occupancy is the population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OccW'(v[i]);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: DEPTH=3 main instance plus a DEPTH=1 instance.
module tb_reg_pipe;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        f1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic [0:0]  occ1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: words in acceptance order (front = oldest) with stage index.
    int          m_pos[$];
    logic [31:0] m_dat[$];
    logic [31:0] m_last = 32'h0;

    always #5 clk = ~clk;

    reg_pipe #(.WIDTH(32), .DEPTH(3), .RESET_DATA(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    reg_pipe #(.WIDTH(32), .DEPTH(1), .RESET_DATA(32'h0)) dut1 (
        .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_data(id1),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1),
        .out_ready(or1), .occupancy(occ1)
    );

    function automatic bit m_ov();
        return (m_pos.size() > 0) && (m_pos[0] == D - 1);
    endfunction

    // A word may move one stage if the slot ahead is free after downstream moves.
    function automatic bit m_ir(input bit fl, input bit ordy);
        int limit;
        int start;
        int np;
        if (fl) return 1'b0;
        limit = D - 1;
        start = (m_ov() && ordy) ? 1 : 0;
        for (int i = start; i < m_pos.size(); i++) begin
            np = (m_pos[i] + 1 <= limit) ? m_pos[i] + 1 : m_pos[i];
            limit = np - 1;
        end
        return limit >= 0;
    endfunction

    task automatic model_edge(input bit fl, input bit iv, input logic [31:0] id, input bit ordy);
        bit ir;
        bit pop;
        int limit;
        ir  = m_ir(fl, ordy);
        pop = m_ov() && ordy;
        if (pop) begin
            void'(m_pos.pop_front());
            void'(m_dat.pop_front());
        end
        if (fl) begin
            m_pos.delete();
            m_dat.delete();
            return;
        end
        limit = D - 1;
        for (int i = 0; i < m_pos.size(); i++) begin
            if (m_pos[i] + 1 <= limit) begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == D - 1) m_last = m_dat[i];
            end
            limit = m_pos[i] - 1;
        end
        if (iv && ir) begin
            m_pos.push_back(0);
            m_dat.push_back(id);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge(flush, in_valid, in_data, out_ready);
        cyc++;
        #1;
    endtask

    task automatic drive(input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic clear_pipe();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (ov1 !== 1'b0) begin errors++; $display("FAIL rst_d1_out_valid: got %b want 0", ov1); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hC0 + k, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
        if (out_data !== 32'hC0) begin errors++; $display("FAIL pre_rst_data: got %h want c0", out_data); end
        // Assert reset mid-clock: outputs must clear without an edge.
        #2;
        rst = 1'b1;
        #1;
        m_pos.delete();
        m_dat.delete();
        m_last = 32'h0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        if (occupancy !== 2'd0) begin errors++; $display("FAIL midrst_occ: got %0d want 0", occupancy); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", out_data); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        tick();
        checks += 1;
        if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_held_occ: got %0d want 0", occupancy); end
        #2;
        rst = 1'b0;
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks += 2;
        if (occupancy !== 2'd1) begin errors++; $display("FAIL post_rst_load: got %0d want 1", occupancy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_early: got %b want 0", out_valid); end
        tick();
        checks += 1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_early2: got %b want 0", out_valid); end
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_arrive: got %b want 1", out_valid); end
        if (out_data !== 32'h77) begin errors++; $display("FAIL post_rst_data: got %h want 77", out_data); end
        tick();
    endtask

    task automatic test_streaming();
        int acc_cyc[int];
        int delivered;
        int max_occ;
        delivered = 0;
        max_occ   = 0;
        clear_pipe();
        for (int k = 1; k <= 10; k++) begin
            if (k <= 5) drive(1'b1, 32'(k), 1'b1, 1'b0);
            else drive(1'b0, 32'h0, 1'b1, 1'b0);
            checks += 4;
            if (in_ready !== m_ir(flush, out_ready)) begin
                errors++; $display("FAIL stream_in_ready: got %b want %b", in_ready, m_ir(flush, out_ready));
            end
            if (out_valid !== m_ov()) begin
                errors++; $display("FAIL stream_out_valid: got %b want %b", out_valid, m_ov());
            end
            if (out_data !== m_last) begin
                errors++; $display("FAIL stream_out_data: got %h want %h", out_data, m_last);
            end
            if (int'(occupancy) !== m_pos.size()) begin
                errors++; $display("FAIL stream_occ: got %0d want %0d", occupancy, m_pos.size());
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (out_valid && out_ready) begin
                delivered++;
                checks += 2;
                if (out_data !== 32'(delivered)) begin
                    errors++; $display("FAIL stream_order: got %h want %h", out_data, delivered);
                end
                if (!acc_cyc.exists(int'(out_data)) || cyc - acc_cyc[int'(out_data)] !== 3) begin
                    errors++; $display("FAIL stream_latency: word %h got cycle %0d want 3", out_data,
                                       acc_cyc.exists(int'(out_data)) ? cyc - acc_cyc[int'(out_data)] : -1);
                end
            end
            if (in_valid && in_ready) acc_cyc[k] = cyc;
            tick();
        end
        checks += 2;
        if (delivered !== 5) begin errors++; $display("FAIL stream_count: got %0d want 5", delivered); end
        if (max_occ !== 3) begin errors++; $display("FAIL stream_max_occ: got %0d want 3", max_occ); end
    endtask

    task automatic test_stall_fill();
        logic [31:0] exp_out [3];
        exp_out[0] = 32'hB;
        exp_out[1] = 32'hC;
        exp_out[2] = 32'hD;
        clear_pipe();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hA + k, 1'b0, 1'b0);
            checks += 1;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_accept: word %0d got %b want 1", k, in_ready); end
            tick();
        end
        drive(1'b1, 32'hD, 1'b0, 1'b0);
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        if (occupancy !== 2'd3) begin errors++; $display("FAIL full_occ: got %0d want 3", occupancy); end
        if (out_data !== 32'hA) begin errors++; $display("FAIL full_head: got %h want a", out_data); end
        tick();
        drive(1'b1, 32'hD, 1'b1, 1'b0);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
            errors++; $display("FAIL drain_a: got %b/%h want 1/a", out_valid, out_data);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks += 1;
            if (out_valid !== 1'b1 || out_data !== exp_out[k]) begin
                errors++; $display("FAIL drain_order: got %b/%h want 1/%h", out_valid, out_data, exp_out[k]);
            end
            tick();
        end
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", out_valid); end
        if (occupancy !== 2'd0) begin errors++; $display("FAIL drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_bubble();
        clear_pipe();
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks += 2;
        if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            errors++; $display("FAIL bubble_head: got %b/%h want 1/11", out_valid, out_data);
        end
        if (occupancy !== 2'd2) begin errors++; $display("FAIL bubble_occ0: got %0d want 2", occupancy); end
        tick();
        checks += 2;
        if (occupancy !== 2'd2) begin errors++; $display("FAIL bubble_occ: got %0d want 2", occupancy); end
        if (out_data !== 32'h11) begin errors++; $display("FAIL bubble_hold: got %h want 11", out_data); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        // 0x22 must already sit next to the output to arrive in one cycle.
        checks += 1;
        if (out_valid !== 1'b1 || out_data !== 32'h22) begin
            errors++; $display("FAIL bubble_collapse: got %b/%h want 1/22", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_flush();
        clear_pipe();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h31 + k, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hFF, 1'b1, 1'b1);
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_deliver: got %b want 1", out_valid); end
        if (out_data !== 32'h31) begin errors++; $display("FAIL flush_deliver_data: got %h want 31", out_data); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks += 3;
        if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        if (out_data !== 32'h31) begin errors++; $display("FAIL flush_data_kept: got %h want 31", out_data); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 1;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got %b want 0", out_valid); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 15) == 0));
            checks += 4;
            if (in_ready !== m_ir(flush, out_ready)) begin
                errors++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, in_ready,
                                   m_ir(flush, out_ready));
            end
            if (out_valid !== m_ov()) begin
                errors++; $display("FAIL rand_out_valid: cycle %0d got %b want %b", cyc, out_valid, m_ov());
            end
            if (out_data !== m_last) begin
                errors++; $display("FAIL rand_out_data: cycle %0d got %h want %h", cyc, out_data, m_last);
            end
            if (int'(occupancy) !== m_pos.size()) begin
                errors++; $display("FAIL rand_occ: cycle %0d got %0d want %0d", cyc, occupancy, m_pos.size());
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_depth1();
        f1 = 1'b0; iv1 = 1'b1; id1 = 32'h33; or1 = 1'b0;
        #1;
        checks += 2;
        if (ir1 !== 1'b1) begin errors++; $display("FAIL d1_empty_ready: got %b want 1", ir1); end
        if (ov1 !== 1'b0) begin errors++; $display("FAIL d1_empty_valid: got %b want 0", ov1); end
        tick();
        checks += 3;
        if (ov1 !== 1'b1 || od1 !== 32'h33) begin errors++; $display("FAIL d1_load: got %b/%h want 1/33", ov1, od1); end
        if (occ1 !== 1'b1) begin errors++; $display("FAIL d1_occ_full: got %0d want 1", occ1); end
        if (ir1 !== 1'b0) begin errors++; $display("FAIL d1_full_ready: got %b want 0", ir1); end
        iv1 = 1'b1; id1 = 32'h55; or1 = 1'b1;
        #1;
        checks += 1;
        if (ir1 !== 1'b1) begin errors++; $display("FAIL d1_pass_ready: got %b want 1", ir1); end
        tick();
        checks += 2;
        if (ov1 !== 1'b1 || od1 !== 32'h55) begin errors++; $display("FAIL d1_pass: got %b/%h want 1/55", ov1, od1); end
        if (occ1 !== 1'b1) begin errors++; $display("FAIL d1_pass_occ: got %0d want 1", occ1); end
        iv1 = 1'b0;
        tick();
        checks += 2;
        if (ov1 !== 1'b0 || occ1 !== 1'b0) begin
            errors++; $display("FAIL d1_drain: got %b/%0d want 0/0", ov1, occ1);
        end
        if (od1 !== 32'h55) begin errors++; $display("FAIL d1_data_kept: got %h want 55", od1); end
        or1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        f1 = 1'b0; iv1 = 1'b0; id1 = 32'h0; or1 = 1'b0;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_bubble();
        test_flush();
        test_random();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised successor to the team's single 32-bit holding register.
- A DEPTH-stage register pipeline of WIDTH-bit words, with a valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count.
- Sits between accelerator datapath blocks (MAC array output, activation unit, writeback) to retime long paths and absorb downstream stalls without losing data.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_DATA, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  pipe accepts in_data this cycle.
- out_valid  output  1  last stage holds a word.
- out_data  output  WIDTH  last-stage word.
- out_ready  input  1  downstream accepts out_data this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset: while rst=1, all stage valid bits=0 and all data registers=RESET_DATA, independent of clk.
  - Outputs: out_valid=0, out_data=RESET_DATA, occupancy=0, in_ready=1 (unless flush=1).
  - First load occurs at the first rising clk edge after rst deasserts.
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i].
- Advance chain, combinational:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[i] = ~v[i] | adv[i+1].
- in_ready = adv[0] & ~flush.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- On each rising edge with adv[i]=1:
  - Stage 0: v[0] <= in_valid & in_ready; d[0] <= in_data only when the input transfers.
  - Stage i>0: v[i] <= v[i-1]; d[i] <= d[i-1] only when v[i-1]=1.
  - Stages with adv[i]=0 hold both valid and data.
- Data registers never load on bubbles: out_data keeps its last value when out_valid=0 (no clearing).
- Latency: an accepted word appears on out_valid/out_data exactly DEPTH cycles after its input transfer, if no stall.
- Throughput: one word per cycle sustained while out_ready=1.
- Bubble collapsing: an empty stage accepts from upstream even while downstream is stalled. A stalled pipe therefore fills to DEPTH words with no loss and no duplication.
- Full: all v=1 and out_ready=0 give in_ready=0. With all v=1 and out_ready=1, in_ready=1 (simultaneous in/out transfer).
- Empty: out_valid=0 and in_ready=1.
- Flush (synchronous):
  - At the edge where flush=1, all v <= 0. Data registers are unchanged.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - An output transfer in the same cycle still counts as delivered downstream.
  - Flush has priority over advance.
- occupancy = popcount(v), registered-state based, updated every edge. Never exceeds DEPTH.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronously). No partial state survives.
- Ordering: words leave in exactly the order accepted.
- The combinational ready path is DEPTH gates long. This is acceptable for DEPTH<=8; larger depths are a later skid-buffer variant.

Decomposition:
- Shared package (accel_pkg), reused by sibling datapath blocks:
  - default data width constant ACC_DATA_W=32;
  - reset polarity constant RST_ACTIVE=1'b1;
  - function for occupancy width (clog2 of DEPTH+1).
- One sub-module: reg_pipe_stage.
  - Holds one valid bit and one WIDTH data register.
  - Inputs: up valid/data, down advance, flush.
  - Outputs: valid, data, own advance.
  - reg_pipe instantiates DEPTH of these in a generate loop and computes occupancy.

Test Plan (WIDTH=32, DEPTH=3 unless noted):
- Reset check: assert rst mid-clock, then release.
  - Expect out_valid=0, occupancy=0 and out_data=RESET_DATA (0) immediately with rst, in_ready=1 while rst=1.
  - Expect first output appears only after the post-release load.
- Streaming: out_ready=1, inputs 0x00000001..0x00000005 on consecutive cycles.
  - Expect each appears exactly 3 cycles after acceptance, in order.
  - Expect occupancy reaches 3 and stays 3.
- Stall and fill: out_ready=0, offer 0xA, 0xB, 0xC, 0xD.
  - Expect 0xA, 0xB, 0xC accepted and in_ready=0 on 0xD, occupancy=3.
  - Then out_ready=1: expect 0xA, 0xB, 0xC drain one per cycle, 0xD accepted in the first drain cycle, output order A, B, C, D.
- Bubble collapse: accept 0x11, idle one cycle, accept 0x22, hold out_ready=0 after 0x11 reaches out.
  - Expect 0x22 advances to stage 1, occupancy=2, 0x11 held on out_data.
- Flush: with occupancy=3, out_ready=1 and in_valid=1 (0xFF) on the flush cycle.
  - Expect the current out word delivered, 0xFF not accepted (in_ready=0).
  - Expect occupancy=0 and out_valid=0 next cycle, out_data unchanged.
- DEPTH=1 variant: full + out_ready=1 + in_valid=1 (0x55).
  - Expect simultaneous transfer, 0x55 on out next cycle, occupancy remains 1.
